// File: rtl/layer2_window_fetcher.sv
// layer2_window_fetcher
// Walks the layer-1 result map in KxK windows, one read per tap, and hands
// each assembled window to the layer-2 datapath over valid/ready. Fetching of
// a new window row waits until the producer has written all rows it touches.
module layer2_window_fetcher #(
    parameter int DATA_W = 128,
    parameter int MAP_W  = 30,
    parameter int K      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             rows_ready,
    output logic [15:0]             read_row_addr,
    output logic [15:0]             read_col_addr,
    output logic                    layer1_result_read_signal,
    input  logic [DATA_W-1:0]       layer1_result_output,
    output logic                    window_valid,
    input  logic                    window_ready,
    output logic [K*K*DATA_W-1:0]   window_data,
    output logic [15:0]             window_row,
    output logic [15:0]             window_col,
    output logic                    busy,
    output logic                    done
);

    localparam logic [15:0] L_LAST     = 16'(MAP_W - K);
    localparam logic [15:0] L_K        = 16'(K);
    localparam logic [15:0] L_KM1      = 16'(K - 1);
    localparam logic [7:0]  L_LAST_TAP = 8'(K * K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROWS,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [15:0]             r_orow;
    logic [15:0]             r_ocol;
    logic [15:0]             r_kr;
    logic [15:0]             r_kc;
    logic [7:0]              r_tap;
    logic [15:0]             r_row_addr;
    logic [15:0]             r_col_addr;
    logic                    r_rd;
    logic                    r_valid;
    logic [K*K*DATA_W-1:0]   r_window_data;
    logic [15:0]             r_win_row;
    logic [15:0]             r_win_col;
    logic                    r_busy;
    logic                    r_done;

    // All rows covered by the current window row have been written.
    logic        w_rows_ok;
    logic [15:0] w_row_need;
    assign w_row_need = r_orow + L_K;
    assign w_rows_ok  = (rows_ready >= w_row_need);

    assign read_row_addr             = r_row_addr;
    assign read_col_addr             = r_col_addr;
    assign layer1_result_read_signal = r_rd;
    assign window_valid              = r_valid;
    assign window_data               = r_window_data;
    assign window_row                = r_win_row;
    assign window_col                = r_win_col;
    assign busy                      = r_busy;
    assign done                      = r_done;

    // Sequencer: window counters, tap issue, capture and handshake.
    // Each transition into FETCH preloads tap 0's address so the first read
    // is driven in the first FETCH cycle; data for the tap driven in a cycle
    // arrives via the falling-edge memory before that cycle's closing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_orow        <= 16'd0;
            r_ocol        <= 16'd0;
            r_kr          <= 16'd0;
            r_kc          <= 16'd0;
            r_tap         <= 8'd0;
            r_row_addr    <= 16'd0;
            r_col_addr    <= 16'd0;
            r_rd          <= 1'b0;
            r_valid       <= 1'b0;
            r_window_data <= '0;
            r_win_row     <= 16'd0;
            r_win_col     <= 16'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_orow  <= 16'd0;
                        r_ocol  <= 16'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_ROWS;
                    end
                end
                S_WAIT_ROWS: begin
                    if (w_rows_ok) begin
                        r_row_addr <= r_orow;
                        r_col_addr <= r_ocol;
                        r_kr       <= 16'd0;
                        r_kc       <= 16'd0;
                        r_tap      <= 8'd0;
                        r_rd       <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_window_data[int'(r_tap)*DATA_W +: DATA_W] <= layer1_result_output;
                    if (r_tap == L_LAST_TAP) begin
                        r_rd      <= 1'b0;
                        r_valid   <= 1'b1;
                        r_win_row <= r_orow;
                        r_win_col <= r_ocol;
                        r_state   <= S_HOLD;
                    end else begin
                        r_tap <= r_tap + 8'd1;
                        if (r_kc == L_KM1) begin
                            r_kc       <= 16'd0;
                            r_kr       <= r_kr + 16'd1;
                            r_row_addr <= r_orow + r_kr + 16'd1;
                            r_col_addr <= r_ocol;
                        end else begin
                            r_kc       <= r_kc + 16'd1;
                            r_col_addr <= r_ocol + r_kc + 16'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_valid && window_ready) begin
                        r_valid <= 1'b0;
                        if (r_ocol < L_LAST) begin
                            r_ocol     <= r_ocol + 16'd1;
                            r_row_addr <= r_orow;
                            r_col_addr <= r_ocol + 16'd1;
                            r_kr       <= 16'd0;
                            r_kc       <= 16'd0;
                            r_tap      <= 8'd0;
                            r_rd       <= 1'b1;
                            r_state    <= S_FETCH;
                        end else if (r_orow < L_LAST) begin
                            r_ocol  <= 16'd0;
                            r_orow  <= r_orow + 16'd1;
                            r_state <= S_WAIT_ROWS;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd    <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer2_window_fetcher.sv
// Directed bench for layer2_window_fetcher: falling-edge memory model holding
// word(r,c) = {r,c} replicated, a handshake monitor that checks every accepted
// window against the expected raster position and contents, and directed
// scenarios for row gating, back-pressure, pass timing and mid-pass reset.
module tb_layer2_window_fetcher;

    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   rows_ready;
    logic [15:0]   read_row_addr;
    logic [15:0]   read_col_addr;
    logic          layer1_result_read_signal;
    logic [DW-1:0] layer1_result_output;
    logic          window_valid;
    logic          window_ready;
    logic [9*DW-1:0] window_data;
    logic [15:0]   window_row;
    logic [15:0]   window_col;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_bad   = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    int exp_r = 0;
    int exp_c = 0;

    layer2_window_fetcher dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .rows_ready                (rows_ready),
        .read_row_addr             (read_row_addr),
        .read_col_addr             (read_col_addr),
        .layer1_result_read_signal (layer1_result_read_signal),
        .layer1_result_output      (layer1_result_output),
        .window_valid              (window_valid),
        .window_ready              (window_ready),
        .window_data               (window_data),
        .window_row                (window_row),
        .window_col                (window_col),
        .busy                      (busy),
        .done                      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word(input int r, input int c);
        logic [15:0] r16;
        logic [15:0] c16;
        r16 = r[15:0];
        c16 = c[15:0];
        return {4{r16, c16}};
    endfunction

    task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: samples address on the falling edge.
    always @(negedge clk) begin
        if (layer1_result_read_signal)
            layer1_result_output <= word(int'(read_row_addr), int'(read_col_addr));
    end

    // Handshake monitor: every accepted window must be the next raster window.
    always @(negedge clk) begin
        if (!rst && window_valid && window_ready) begin
            chk_eq("win_row", 128'(window_row), 128'(exp_r));
            chk_eq("win_col", 128'(window_col), 128'(exp_c));
            for (int k = 0; k < 9; k++)
                chk_eq("win_slot", window_data[k*DW +: DW], word(exp_r + k / 3, exp_c + k % 3));
            win_cnt++;
            if (exp_c < 27) begin
                exp_c++;
            end else begin
                exp_c = 0;
                exp_r++;
            end
        end
        if (!rst && done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pass();
        exp_r   = 0;
        exp_c   = 0;
        win_cnt = 0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        int n;
        int reads;
        int dc;
        rst = 1'b1;
        start = 1'b0;
        rows_ready = 16'd0;
        window_ready = 1'b0;
        layer1_result_output = '0;
        tick();
        tick();
        // reset state
        chk_eq("rst_read", 128'(layer1_result_read_signal), 128'd0);
        chk_eq("rst_row_addr", 128'(read_row_addr), 128'd0);
        chk_eq("rst_valid", 128'(window_valid), 128'd0);
        chk_eq("rst_busy", 128'(busy), 128'd0);
        chk_eq("rst_done", 128'(done), 128'd0);
        chk_eq("rst_data", window_data[4*DW +: DW], 128'd0);
        rst = 1'b0;
        tick();

        // ---- pass 1: row gating ----
        rows_ready = 16'd2;
        new_pass();
        chk_eq("busy_after_start", 128'(busy), 128'd1);
        reads = 0;
        for (int i = 0; i < 50; i++) begin
            if (layer1_result_read_signal) reads++;
            tick();
        end
        chk_eq("gated_reads", 128'(reads), 128'd0);
        rows_ready = 16'd3;
        tick();
        chk_eq("first_read", 128'(layer1_result_read_signal), 128'd1);
        chk_eq("first_row_addr", 128'(read_row_addr), 128'd0);
        chk_eq("first_col_addr", 128'(read_col_addr), 128'd0);
        for (int i = 0; i < 4; i++) tick();
        chk_eq("tap4_row", 128'(read_row_addr), 128'd1);
        chk_eq("tap4_col", 128'(read_col_addr), 128'd1);
        for (int i = 0; i < 5; i++) tick();
        chk_eq("valid_f9", 128'(window_valid), 128'd1);
        chk_eq("read_off_hold", 128'(layer1_result_read_signal), 128'd0);
        chk_eq("w00_slot4", window_data[4*DW +: DW], word(1, 1));
        chk_eq("w00_slot8", window_data[8*DW +: DW], word(2, 2));

        // ---- back-pressure on window (0,5) ----
        window_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (window_valid && window_col == 16'd5) break;
            tick();
        end
        chk_eq("reach_0_5", 128'(window_valid && window_col == 16'd5), 128'd1);
        window_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_eq("stall_valid", 128'(window_valid), 128'd1);
            chk_eq("stall_read", 128'(layer1_result_read_signal), 128'd0);
            chk_eq("stall_slot4", window_data[4*DW +: DW], word(1, 6));
        end
        window_ready = 1'b1;
        tick();
        chk_eq("valid_drop", 128'(window_valid), 128'd0);
        chk_eq("next_col_addr", 128'(read_col_addr), 128'd6);
        chk_eq("next_read", 128'(layer1_result_read_signal), 128'd1);

        // ---- last-column handshake on (3,27), then gated row 4 ----
        rows_ready = 16'd6;
        for (int i = 0; i < 4000; i++) begin
            if (window_valid && window_row == 16'd3 && window_col == 16'd27) break;
            tick();
        end
        chk_eq("reach_3_27", 128'(window_valid && window_row == 16'd3 && window_col == 16'd27), 128'd1);
        reads = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (layer1_result_read_signal) reads++;
        end
        chk_eq("row4_gated", 128'(reads), 128'd0);
        chk_eq("row4_busy", 128'(busy), 128'd1);
        rows_ready = 16'd7;
        tick();
        chk_eq("row4_read", 128'(layer1_result_read_signal), 128'd1);
        chk_eq("row4_row_addr", 128'(read_row_addr), 128'd4);
        chk_eq("row4_col_addr", 128'(read_col_addr), 128'd0);
        rows_ready = 16'd30;
        for (int i = 0; i < 20000; i++) begin
            if (done) break;
            tick();
        end
        chk_eq("pass1_done", 128'(done), 128'd1);
        chk_eq("pass1_windows", 128'(win_cnt), 128'd784);
        tick();
        chk_eq("done_one_cycle", 128'(done), 128'd0);
        chk_eq("busy_fall", 128'(busy), 128'd0);
        chk_eq("pass1_done_cnt", 128'(done_cnt), 128'd1);

        // ---- pass 2: free-running timing ----
        exp_r = 0;
        exp_c = 0;
        win_cnt = 0;
        start = 1'b1;
        n = 0;
        for (int i = 0; i < 9000; i++) begin
            tick();
            n++;
            start = 1'b0;
            if (done) break;
        end
        chk_eq("pass2_cycles", 128'(n), 128'(784 * 10 + 29));
        chk_eq("pass2_windows", 128'(win_cnt), 128'd784);
        chk_eq("w27_slot8", window_data[8*DW +: DW], word(29, 29));
        tick();
        chk_eq("pass2_done_cnt", 128'(done_cnt), 128'd2);

        // ---- pass 3: start while busy ignored, then reset at tap 4 ----
        new_pass();
        for (int i = 0; i < 200; i++) begin
            if (window_valid && window_col == 16'd2) break;
            tick();
        end
        chk_eq("reach_0_2", 128'(window_valid && window_col == 16'd2), 128'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (window_valid) break;
            tick();
        end
        chk_eq("busy_start_col", 128'(window_col), 128'd3);
        chk_eq("busy_start_cnt", 128'(win_cnt), 128'd3);
        tick();
        chk_eq("w04_tap0", 128'(read_col_addr), 128'd4);
        for (int i = 0; i < 4; i++) tick();
        chk_eq("w04_tap4_col", 128'(read_col_addr), 128'd5);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("arst_read", 128'(layer1_result_read_signal), 128'd0);
        chk_eq("arst_row", 128'(read_row_addr), 128'd0);
        chk_eq("arst_col", 128'(read_col_addr), 128'd0);
        chk_eq("arst_busy", 128'(busy), 128'd0);
        chk_eq("arst_wcol", 128'(window_col), 128'd0);
        chk_eq("arst_data", window_data[0 +: DW], 128'd0);
        dc = done_cnt;
        tick();
        rst = 1'b0;
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || layer1_result_read_signal) reads++;
        end
        chk_eq("idle_after_rst", 128'(reads), 128'd0);
        chk_eq("no_done_rst", 128'(done_cnt), 128'(dc));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
